pixel_mem_arbiter: RTL and testbench
====================================

PIXEL_MEM_ARBITER -- requirements
Module: pixel_mem_arbiter

Interface
REQ-001 Parameter TILES_X, default 40, tiles per row (16-pixel tiles, 640 px).
REQ-002 Parameter TILES_Y, default 30, tile rows (16-pixel tiles, 480 px).
REQ-003 Parameter DW, default 8, tile data width.
REQ-004 Parameter WR_BLANK_ONLY, default 0: 1 restricts writes to vertical blank (y >= 480).
REQ-005 Port clk, input, 1, system clock (100 MHz); the only clock.
REQ-006 Port reset, input, 1, synchronous, active-high reset.
REQ-007 Port p_tick, input, 1, pixel tick from the sync generator (1 of every 4 clk).
REQ-008 Port video_on, input, 1, sync generator active-display flag.
REQ-009 Port x / y, input, 10 each, sync generator pixel counters.
REQ-010 Port wr_req, input, 1, game-logic write request; held until wr_ack.
REQ-011 Port wr_addr, input, 11, tile address, row*TILES_X+col.
REQ-012 Port wr_data, input, DW, tile value to write.
REQ-013 Port wr_ack, output, 1, one-cycle pulse: request consumed.
REQ-014 Port wr_err, output, 1, one-cycle pulse with wr_ack when wr_addr >= TILES_X*TILES_Y.
REQ-015 Port mem_addr / mem_we / mem_wdata, output, 11 / 1 / DW, registered single-port RAM controls.
REQ-016 Port mem_rdata, input, DW, RAM read data, valid one clk after a read address is driven.
REQ-017 Port pix_data / pix_valid, output, DW / 1, tile value for the current pixel and its qualifier.
REQ-018 Port frame_tick / frame_cnt, output, 1 / 8, vblank-start pulse and frame counter.

Function
REQ-019 Arbiter FSM states: IDLE, DISP (display read issued), WR (write issued); one state per clk, no multi-cycle holds.
REQ-020 Display slot: any cycle with p_tick=1 and video_on=1; at t+1, FSM enters DISP, mem_addr = y[8:4]*TILES_X + x[9:4], mem_we=0.
REQ-021 Display path latency is fixed at 3 clk: slot at t -> pix_data = mem_rdata captured at end of t+2, visible from t+3 until the next update.
REQ-022 A p_tick cycle with video_on=0 issues no read; pix_data=0 and pix_valid=0 from t+3 on.
REQ-023 Write grant at t requires: wr_req=1, not a display slot, wr_ack=0 at t, and (WR_BLANK_ONLY=0 or y >= 480).
REQ-024 On grant at t: at t+1, FSM enters WR, wr_ack=1, mem_addr=wr_addr, mem_wdata=wr_data, mem_we=1.
REQ-025 Out-of-range wr_addr: wr_ack=1 and wr_err=1 at t+1, mem_we stays 0, and the RAM contents are unchanged.
REQ-026 Display slot and wr_req in the same cycle: display wins, write deferred; worst-case write wait is 2 clk when WR_BLANK_ONLY=0.
REQ-027 No grant in a cycle where wr_ack=1, so a held wr_req never causes a double write.
REQ-028 Non-grant, non-slot cycles: FSM enters IDLE, mem_we=0, mem_addr holds its last value.
REQ-029 Vblank start: p_tick=1, x=0, y=480 -> frame_tick=1 for one clk at t+1, frame_cnt increments, 255 wraps to 0.
REQ-030 Address arithmetic is unsigned 11-bit; x >= 640 or y >= 480 never produces a display read.

Reset
REQ-031 Synchronous reset forces: FSM=IDLE; mem_addr=0, mem_we=0, mem_wdata=0; wr_ack=0, wr_err=0; pix_data=0, pix_valid=0; frame_tick=0, frame_cnt=0.
REQ-032 Reset asserted mid-operation discards in-flight display reads; the write in progress is not acked or written if it had not reached t+1 before reset.
REQ-033 After reset deasserts, a still-held wr_req is granted under REQ-023 rules.

Verification
REQ-034 Scenario: video_on=1, x=37, y=18, mem_rdata=0x5A one clk after the read -> mem_addr=42 (1*40+2) at t+1, pix_data=0x5A and pix_valid=1 at t+3.
REQ-035 Scenario: wr_req with addr 100, data 0x3C, asserted in a display-slot cycle -> no write at t+1, then exactly one mem_we pulse to 100/0x3C and one wr_ack within 2 clk.
REQ-036 Scenario: wr_req held 5 clk after ack -> exactly one mem_we pulse and one wr_ack per grant, never back-to-back on the same request.
REQ-037 Scenario: wr_addr=1200 -> wr_ack=1 and wr_err=1 together, mem_we=0 throughout.
REQ-038 Scenario: WR_BLANK_ONLY=1, wr_req at y=100 -> no ack until y reaches 480; then ack within 2 clk.
REQ-039 Scenario: run 256 frames, then assert reset mid-line -> frame_cnt wraps 255 to 0 with one frame_tick per frame; all outputs read 0 on the cycle after reset.

Source files
------------

// File: rtl/pixel_mem_arbiter.sv
// Pixel memory arbiter: shares one single-port tile RAM between the display
// read path (one read per active pixel tick) and game-logic tile writes.
// Display reads always win; writes fill the idle cycles between pixel ticks.
module pixel_mem_arbiter #(
    parameter int TILES_X       = 40,
    parameter int TILES_Y       = 30,
    parameter int DW            = 8,
    parameter int WR_BLANK_ONLY = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p_tick,
    input  logic          video_on,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic          wr_req,
    input  logic [10:0]   wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    output logic          wr_err,
    output logic [10:0]   mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] pix_data,
    output logic          pix_valid,
    output logic          frame_tick,
    output logic [7:0]    frame_cnt
);

    localparam logic [11:0] N_TILES = 12'(TILES_X * TILES_Y);

    typedef enum logic [1:0] {IDLE, DISP, WR} state_t;

    state_t        state_q, state_d;
    logic [10:0]   mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          wr_ack_q, wr_ack_d;
    logic          wr_err_q, wr_err_d;
    logic          upd_p0_q, upd_p0_d;
    logic          upd_p1_q, upd_p1_d;
    logic          vld_p1_q, vld_p1_d;
    logic [DW-1:0] pix_data_q, pix_data_d;
    logic          pix_valid_q, pix_valid_d;
    logic          frame_tick_q, frame_tick_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;

    logic in_active;
    logic disp_slot;
    logic wr_zone_ok;
    logic wr_addr_ok;
    logic grant;
    logic vblank_start;

    // Tile index of the pixel: 16x16 tiles, row-major, unsigned 11-bit.
    function automatic logic [10:0] tile_addr(input logic [9:0] px, input logic [9:0] py);
        logic [10:0] row;
        row = 11'(py[8:4]);
        return 11'(row * 11'(TILES_X)) + 11'(px[9:4]);
    endfunction

    // Slot and grant qualification for the current cycle.
    always_comb begin
        in_active    = (x < 10'd640) && (y < 10'd480);
        disp_slot    = p_tick && video_on && in_active;
        wr_zone_ok   = (WR_BLANK_ONLY == 0) || (y >= 10'd480);
        wr_addr_ok   = ({1'b0, wr_addr} < N_TILES);
        // wr_ack_q blocks a second grant to a request that is still held.
        grant        = wr_req && !disp_slot && !wr_ack_q && wr_zone_ok;
        vblank_start = p_tick && (x == 10'd0) && (y == 10'd480);
    end

    // Arbiter next state and registered RAM/handshake controls.
    always_comb begin
        state_d     = IDLE;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        wr_ack_d    = 1'b0;
        wr_err_d    = 1'b0;
        if (disp_slot) begin
            state_d    = DISP;
            mem_addr_d = tile_addr(x, y);
        end else if (grant) begin
            state_d     = WR;
            wr_ack_d    = 1'b1;
            wr_err_d    = !wr_addr_ok;
            mem_we_d    = wr_addr_ok;
            mem_addr_d  = wr_addr;
            mem_wdata_d = wr_data;
        end
    end

    // Display return pipeline and frame counter next values.
    always_comb begin
        // p0: pixel tick seen, read address being driven
        upd_p0_d = p_tick;
        // p1: RAM data for a DISP read arrives this cycle
        upd_p1_d = upd_p0_q;
        vld_p1_d = (state_q == DISP);
        // p2: capture tile value (or blank) for the pixel output
        pix_data_d  = pix_data_q;
        pix_valid_d = pix_valid_q;
        if (upd_p1_q) begin
            pix_valid_d = vld_p1_q;
            pix_data_d  = vld_p1_q ? mem_rdata : '0;
        end
        frame_tick_d = vblank_start;
        frame_cnt_d  = vblank_start ? frame_cnt_q + 8'd1 : frame_cnt_q;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Output and pipeline registers; reset drops any in-flight read or write.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            wr_ack_q     <= 1'b0;
            wr_err_q     <= 1'b0;
            upd_p0_q     <= 1'b0;
            upd_p1_q     <= 1'b0;
            vld_p1_q     <= 1'b0;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
            frame_tick_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            wr_ack_q     <= wr_ack_d;
            wr_err_q     <= wr_err_d;
            upd_p0_q     <= upd_p0_d;
            upd_p1_q     <= upd_p1_d;
            vld_p1_q     <= vld_p1_d;
            pix_data_q   <= pix_data_d;
            pix_valid_q  <= pix_valid_d;
            frame_tick_q <= frame_tick_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign wr_ack     = wr_ack_q;
    assign wr_err     = wr_err_q;
    assign pix_data   = pix_data_q;
    assign pix_valid  = pix_valid_q;
    assign frame_tick = frame_tick_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// Directed bench for pixel_mem_arbiter: default instance with a RAM model,
// plus a WR_BLANK_ONLY=1 instance sharing the same stimulus.
module tb_pixel_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        p_tick;
    logic        video_on;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        wr_req;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;

    logic        wr_ack, wr_err, mem_we, pix_valid, frame_tick;
    logic [10:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata, pix_data, frame_cnt;

    logic        b_ack, b_err, b_we, b_valid, b_ftick;
    logic [10:0] b_addr;
    logic [7:0]  b_wdata, b_rdata, b_pix, b_fcnt;

    logic [7:0]  ram [0:2047];

    int checks   = 0;
    int failures = 0;

    pixel_mem_arbiter u_dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
        .x(x), .y(y), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_err(wr_err), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pix_data(pix_data),
        .pix_valid(pix_valid), .frame_tick(frame_tick), .frame_cnt(frame_cnt)
    );

    pixel_mem_arbiter #(.WR_BLANK_ONLY(1)) u_blank (
        .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
        .x(x), .y(y), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(b_ack), .wr_err(b_err), .mem_addr(b_addr), .mem_we(b_we),
        .mem_wdata(b_wdata), .mem_rdata(b_rdata), .pix_data(b_pix),
        .pix_valid(b_valid), .frame_tick(b_ftick), .frame_cnt(b_fcnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port RAM: write-enable honoured, read data one clk after address.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (mem_addr !== 11'd0 || mem_we !== 1'b0 || mem_wdata !== 8'd0) begin
            failures++;
            $display("FAIL reset_mem got addr=%0d we=%b wdata=%0h exp 0/0/0", mem_addr, mem_we, mem_wdata);
        end
        checks++;
        if (wr_ack !== 1'b0 || wr_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_ack got ack=%b err=%b exp 0/0", wr_ack, wr_err);
        end
        checks++;
        if (pix_data !== 8'd0 || pix_valid !== 1'b0 || frame_tick !== 1'b0 || frame_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_pix got pix=%0h v=%b ft=%b fc=%0d exp all 0", pix_data, pix_valid, frame_tick, frame_cnt);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_display();
        p_tick = 1'b1; video_on = 1'b1; x = 10'd37; y = 10'd18;
        tick();
        p_tick = 1'b0;
        checks++;
        if (mem_addr !== 11'd42 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL disp_addr got addr=%0d we=%b exp 42/0", mem_addr, mem_we);
        end
        tick();
        checks++;
        if (pix_valid !== 1'b0) begin
            failures++;
            $display("FAIL disp_early got valid=%b exp 0", pix_valid);
        end
        tick();
        checks++;
        if (pix_data !== 8'h5A || pix_valid !== 1'b1) begin
            failures++;
            $display("FAIL disp_data got pix=%0h v=%b exp 5a/1", pix_data, pix_valid);
        end
        tick();
        checks++;
        if (pix_data !== 8'h5A || pix_valid !== 1'b1) begin
            failures++;
            $display("FAIL disp_hold got pix=%0h v=%b exp 5a/1", pix_data, pix_valid);
        end
    endtask

    task automatic test_blank();
        p_tick = 1'b1; video_on = 1'b0; x = 10'd37; y = 10'd18;
        tick();
        p_tick = 1'b0;
        checks++;
        if (mem_addr !== 11'd42 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL blank_noread got addr=%0d we=%b exp 42/0", mem_addr, mem_we);
        end
        tick();
        tick();
        checks++;
        if (pix_data !== 8'd0 || pix_valid !== 1'b0) begin
            failures++;
            $display("FAIL blank_pix got pix=%0h v=%b exp 0/0", pix_data, pix_valid);
        end
        p_tick = 1'b1; video_on = 1'b1; x = 10'd700; y = 10'd18;
        tick();
        checks++;
        if (mem_addr !== 11'd42) begin
            failures++;
            $display("FAIL xrange_noread got addr=%0d exp 42", mem_addr);
        end
        x = 10'd37; y = 10'd500;
        tick();
        p_tick = 1'b0; video_on = 1'b0;
        checks++;
        if (mem_addr !== 11'd42) begin
            failures++;
            $display("FAIL yrange_noread got addr=%0d exp 42", mem_addr);
        end
        tick();
        tick();
    endtask

    task automatic test_write_defer();
        p_tick = 1'b1; video_on = 1'b1; x = 10'd37; y = 10'd18;
        wr_req = 1'b1; wr_addr = 11'd100; wr_data = 8'h3C;
        tick();
        p_tick = 1'b0;
        checks++;
        if (wr_ack !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 11'd42) begin
            failures++;
            $display("FAIL defer_slot got ack=%b we=%b addr=%0d exp 0/0/42", wr_ack, mem_we, mem_addr);
        end
        tick();
        wr_req = 1'b0;
        checks++;
        if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 11'd100 || mem_wdata !== 8'h3C || wr_err !== 1'b0) begin
            failures++;
            $display("FAIL defer_write got ack=%b we=%b addr=%0d data=%0h err=%b exp 1/1/100/3c/0",
                     wr_ack, mem_we, mem_addr, mem_wdata, wr_err);
        end
        tick();
        checks++;
        if (wr_ack !== 1'b0 || mem_we !== 1'b0 || ram[100] !== 8'h3C) begin
            failures++;
            $display("FAIL defer_after got ack=%b we=%b ram100=%0h exp 0/0/3c", wr_ack, mem_we, ram[100]);
        end
        video_on = 1'b0;
    endtask

    task automatic test_back_to_back();
        int  acks = 0;
        int  wes = 0;
        int  b2b = 0;
        logic prev = 1'b0;
        wr_req = 1'b1; wr_addr = 11'd5; wr_data = 8'h11;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (wr_ack === 1'b1) acks++;
            if (mem_we === 1'b1) wes++;
            if (prev && wr_ack === 1'b1) b2b++;
            prev = wr_ack;
        end
        wr_req = 1'b0;
        tick();
        checks++;
        if (acks != 3 || wes != 3) begin
            failures++;
            $display("FAIL held_count got acks=%0d wes=%0d exp 3/3", acks, wes);
        end
        checks++;
        if (b2b != 0) begin
            failures++;
            $display("FAIL held_b2b got %0d back-to-back acks exp 0", b2b);
        end
    endtask

    task automatic test_addr_err();
        wr_req = 1'b1; wr_addr = 11'd1200; wr_data = 8'hFF;
        tick();
        wr_req = 1'b0;
        checks++;
        if (wr_ack !== 1'b1 || wr_err !== 1'b1 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL err_1200 got ack=%b err=%b we=%b exp 1/1/0", wr_ack, wr_err, mem_we);
        end
        tick();
        checks++;
        if (wr_ack !== 1'b0 || wr_err !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL err_clear got ack=%b err=%b we=%b exp 0/0/0", wr_ack, wr_err, mem_we);
        end
        wr_req = 1'b1; wr_addr = 11'd1199; wr_data = 8'h77;
        tick();
        wr_req = 1'b0;
        checks++;
        if (wr_ack !== 1'b1 || wr_err !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 11'd1199) begin
            failures++;
            $display("FAIL err_1199 got ack=%b err=%b we=%b addr=%0d exp 1/0/1/1199", wr_ack, wr_err, mem_we, mem_addr);
        end
        tick();
    endtask

    task automatic test_blank_only();
        int early = 0;
        logic seen = 1'b0;
        p_tick = 1'b0; video_on = 1'b0; x = 10'd100; y = 10'd100;
        wr_req = 1'b1; wr_addr = 11'd7; wr_data = 8'h22;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (b_ack === 1'b1 || b_we === 1'b1) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL blankonly_wait got %0d early acks exp 0", early);
        end
        wr_req = 1'b0;
        tick();
        tick();
        wr_req = 1'b1; y = 10'd480;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (b_ack === 1'b1 && b_we === 1'b1 && b_addr === 11'd7) seen = 1'b1;
        end
        wr_req = 1'b0;
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL blankonly_ack got ack_seen=%b exp 1", seen);
        end
        y = 10'd0;
        tick();
        tick();
    endtask

    task automatic test_frame_reset();
        int ticks = 0;
        int long_ticks = 0;
        for (int f = 0; f < 256; f++) begin
            p_tick = 1'b1; x = 10'd0; y = 10'd480;
            tick();
            p_tick = 1'b0;
            if (frame_tick === 1'b1) ticks++;
            tick();
            if (frame_tick === 1'b1) long_ticks++;
            if (f == 254) begin
                checks++;
                if (frame_cnt !== 8'd255) begin
                    failures++;
                    $display("FAIL frame_255 got %0d exp 255", frame_cnt);
                end
            end
        end
        checks++;
        if (frame_cnt !== 8'd0 || ticks != 256 || long_ticks != 0) begin
            failures++;
            $display("FAIL frame_wrap got cnt=%0d ticks=%0d long=%0d exp 0/256/0", frame_cnt, ticks, long_ticks);
        end
        p_tick = 1'b1; x = 10'd0; y = 10'd480;
        tick();
        p_tick = 1'b0;
        tick();
        checks++;
        if (frame_cnt !== 8'd1) begin
            failures++;
            $display("FAIL frame_one got %0d exp 1", frame_cnt);
        end
        // Mid-line: display read in flight, then reset with a write pending.
        p_tick = 1'b1; video_on = 1'b1; x = 10'd37; y = 10'd18;
        tick();
        p_tick = 1'b0;
        reset = 1'b1; wr_req = 1'b1; wr_addr = 11'd9; wr_data = 8'h44;
        tick();
        checks++;
        if (mem_addr !== 11'd0 || mem_we !== 1'b0 || mem_wdata !== 8'd0 || wr_ack !== 1'b0 || wr_err !== 1'b0) begin
            failures++;
            $display("FAIL midreset_mem got addr=%0d we=%b wd=%0h ack=%b err=%b exp all 0",
                     mem_addr, mem_we, mem_wdata, wr_ack, wr_err);
        end
        checks++;
        if (pix_data !== 8'd0 || pix_valid !== 1'b0 || frame_tick !== 1'b0 || frame_cnt !== 8'd0) begin
            failures++;
            $display("FAIL midreset_pix got pix=%0h v=%b ft=%b fc=%0d exp all 0", pix_data, pix_valid, frame_tick, frame_cnt);
        end
        reset = 1'b0;
        tick();
        wr_req = 1'b0;
        checks++;
        if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 11'd9 || mem_wdata !== 8'h44) begin
            failures++;
            $display("FAIL postreset_grant got ack=%b we=%b addr=%0d wd=%0h exp 1/1/9/44", wr_ack, mem_we, mem_addr, mem_wdata);
        end
        tick();
        tick();
        checks++;
        if (pix_valid !== 1'b0 || pix_data !== 8'd0) begin
            failures++;
            $display("FAIL midreset_inflight got pix=%0h v=%b exp 0/0", pix_data, pix_valid);
        end
        video_on = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
        ram[42] = 8'h5A;
        b_rdata = 8'h00;
        reset = 1'b1; p_tick = 1'b0; video_on = 1'b0; x = '0; y = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        test_reset();
        test_display();
        test_blank();
        test_write_defer();
        test_back_to_back();
        test_addr_err();
        test_blank_only();
        test_frame_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
